fft_mag_buffer: RTL

//  Sits between the FFT core and graphics_controller. Takes the FFT's complex bin stream, converts each bin to an

---
 rtl/fft_mag_buffer.sv | 111 +++++++++++
 1 files changed

// File: rtl/fft_mag_buffer.sv
// rtl/fft_mag_buffer.sv - FFT bin magnitude estimator with back/front frame banks published on vsync
module fft_mag_buffer #(
  parameter int WIDTH  = 12,
  parameter int N      = 256,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic                    clk_25MHz,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  input  logic [ADDR_W-1:0]       in_idx,
  input  logic                    in_last,
  input  logic                    vsync,
  output logic [WIDTH:0]          freq_samples [N],
  output logic                    fft_done
);

  typedef enum logic [1:0] {FILL, DRAIN, PENDING, PUBLISH} state_t;

  state_t              state, state_nxt;
  logic [1:0]          drain_cnt;
  logic                vsync_d;
  logic [WIDTH:0]      back [N];

  logic                v1, v2;
  logic [WIDTH-1:0]    a1, b1, mx2, mn2;
  logic [ADDR_W-1:0]   idx1, idx2;
  logic [WIDTH+1:0]    sum;
  logic [WIDTH:0]      mag;
  logic                in_range;
  logic                accept;

  function automatic logic [WIDTH-1:0] abs_u(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  // Gated by rst so upstream never sees ready while the block is held in reset.
  assign in_ready = rst & (state == FILL);
  assign accept   = in_valid & in_ready;

  assign sum      = {2'b00, mx2} + {2'b00, (mn2 >> 2)};
  assign mag      = sum[WIDTH+1] ? '1 : sum[WIDTH:0];
  assign in_range = ({1'b0, idx2} < (ADDR_W+1)'(N));

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && in_last) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) state_nxt = PENDING;
      PENDING: if (vsync_d && !vsync) state_nxt = PUBLISH;
      PUBLISH: state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk_25MHz or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      drain_cnt <= 2'd0;
      vsync_d   <= 1'b1;
      fft_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      vsync_d   <= vsync;
      fft_done  <= (state == PUBLISH);
    end
  end

  // Stage 1 takes absolute values, stage 2 orders them, stage 3 writes the estimate.
  always_ff @(posedge clk_25MHz or negedge rst) begin
    if (!rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      a1   <= '0;
      b1   <= '0;
      mx2  <= '0;
      mn2  <= '0;
      idx1 <= '0;
      idx2 <= '0;
    end else begin
      v1   <= accept;
      a1   <= abs_u(in_re);
      b1   <= abs_u(in_im);
      idx1 <= in_idx;
      v2   <= v1;
      mx2  <= (a1 > b1) ? a1 : b1;
      mn2  <= (a1 > b1) ? b1 : a1;
      idx2 <= idx1;
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        back[i]         <= '0;
        freq_samples[i] <= '0;
      end
    end else if (state == PUBLISH) begin
      for (int i = 0; i < N; i++) begin
        freq_samples[i] <= back[i];
        back[i]         <= '0;
      end
    end else if (v2 && in_range) begin
      back[idx2] <= mag;
    end
  end

endmodule
